wb_ibnalhaytham_ctrl: RTL and testbench
=======================================

Name: wb_ibnalhaytham_ctrl

Overview:
- Wishbone classic responder: the target end of the Caravel management-SoC bus, feeding the ibnalhaytham core.
- Gives firmware control of core reset/halt, PC readback, and word-by-word instruction-memory loading through a valid/ready write port with timeout.
- Sits inside wrapped_ibnalhaytham on the wbs_* pins, beside the core instance; its outputs go through the wrapper's tristate buffers.

Parameters:
- BASE_ADDR, 32'h3000_0000: block base address; only wbs_adr_i[31:8] is compared against BASE_ADDR[31:8].
- IMEM_AW, 8: instruction-memory word-address width.
- TIMEOUT, 16: maximum cycles to wait for imem_wr_ready_i (range 1..255).

Ports:
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- core_pc_i  in  32  current core PC.
- core_rst_o  out  1  core reset, active high.
- core_halt_o  out  1  core clock-enable gate, active high.
- imem_wr_valid_o  out  1  imem write request.
- imem_wr_ready_i  in  1  imem accepts write.
- imem_wr_addr_o  out  IMEM_AW  imem word address.
- imem_wr_data_o  out  32  imem write data.
- imem_wr_mask_o  out  4  byte-write mask, copied from wbs_sel_i.

Behaviour:
- Selected = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & !wbs_ack_o. Unselected cycles are never acked.
- Register map (offset = adr[7:2]*4):
  - 0x00 CTRL rw: [0] core_rst, reset 1; [1] core_halt, reset 0.
  - 0x04 STATUS: [0] imem write pending, ro; [1] timeout sticky, write 1 to clear.
  - 0x08 PC ro: core_pc_i.
  - 0x0C WRCOUNT ro: [15:0] completed imem writes, wraps 0xFFFF->0.
  - 0x10 IMEM_ADDR rw: [IMEM_AW-1:0].
  - 0x14 IMEM_DATA wo: a write launches an imem write; reads return 0.
  - Any other offset: reads 0, writes ignored, still acked.
- Byte selects: apply to CTRL and IMEM_ADDR writes (only byte 0 and byte 1 lanes are relevant). The STATUS W1C uses sel[0].
- FSM states: IDLE, WAIT_MEM, ACK.
  - IDLE, selected and not an IMEM_DATA write: perform the register read/write, go to ACK. wbs_ack_o is high in cycle N+1 when the request is sampled at edge N.
  - IDLE, selected IMEM_DATA write: latch data, mask and address; imem_wr_valid_o=1 next cycle; go to WAIT_MEM.
  - WAIT_MEM: valid, addr, data and mask are held stable. When valid and ready are both high at an edge:
    - drop valid;
    - IMEM_ADDR increments (wraps at 2^IMEM_AW);
    - WRCOUNT increments;
    - go to ACK.
  - WAIT_MEM timeout: if TIMEOUT cycles elapse with valid high and no ready, drop valid, set the sticky bit, and go to ACK. Address and count are unchanged.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE. Acks are never back-to-back. The earliest re-accept is the cycle after ack.
- If cyc drops during WAIT_MEM, the imem write still completes. The ack cycle still occurs and is ignored by the initiator.
- wbs_dat_o is registered, valid only while ack=1, and 0 otherwise.
- Reset (sync, any state, including mid-WAIT_MEM) forces:
  - FSM to IDLE;
  - ack=0, dat_o=0, imem_wr_valid_o=0;
  - CTRL=0x1, IMEM_ADDR=0, WRCOUNT=0, sticky=0, timeout counter=0;
  - imem_wr_addr_o, imem_wr_data_o and imem_wr_mask_o to 0.
- core_rst_o and core_halt_o are direct register outputs: they change in the cycle after the write edge.

Test Plan:
- Reset, then read CTRL: ack one cycle after stb, dat_o=0x00000001, core_rst_o=1, core_halt_o=0.
- Write CTRL=0x2 with sel=4'b0001: core_rst_o=0 and core_halt_o=1 next cycle; readback 0x2.
- IMEM_ADDR=0xFE; write IMEM_DATA 0xDEADBEEF then 0x12345678, ready high after 2 cycles each. Required:
  - imem sees addr 0xFE then 0xFF with those data and mask 0xF;
  - IMEM_ADDR wraps to 0x00;
  - WRCOUNT=2;
  - each ack comes one cycle after the ready handshake.
- Hold ready low through an IMEM_DATA write: valid drops after 16 cycles, ack follows, STATUS=0x2, IMEM_ADDR and WRCOUNT unchanged. Writing STATUS=0x2 clears it to 0.
- Access adr 0x3100_0000: no ack ever. Read offset 0x40: acked, data 0. Read PC with core_pc_i=0x00000120: returns 0x00000120.
- Assert wb_rst_i during WAIT_MEM: valid=0 and ack=0 next cycle, CTRL=0x1, IMEM_ADDR=0, WRCOUNT=0.

Source files
------------

// File: rtl/wb_ibnalhaytham_ctrl_if.sv
// Wishbone classic bus between the Caravel management SoC and the ibnalhaytham control block.
interface wb_ibnalhaytham_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_ibnalhaytham_ctrl.sv
// Wishbone responder giving firmware core reset/halt control, PC readback and
// word-by-word instruction-memory loading through a valid/ready port with timeout.
//
// state       | meaning
// ST_IDLE     | waiting for a selected bus cycle
// ST_WAIT_MEM | imem write offered, waiting for ready or timeout
// ST_ACK      | single-cycle bus acknowledge
module wb_ibnalhaytham_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IMEM_AW   = 8,
    parameter int          TIMEOUT   = 16
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wb_ibnalhaytham_ctrl_if.slave     wbs,
    input  logic [31:0]               core_pc_i,
    output logic                      core_rst_o,
    output logic                      core_halt_o,
    output logic                      imem_wr_valid_o,
    input  logic                      imem_wr_ready_i,
    output logic [IMEM_AW-1:0]        imem_wr_addr_o,
    output logic [31:0]               imem_wr_data_o,
    output logic [3:0]                imem_wr_mask_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_MEM = 2'd1;
    localparam logic [1:0] ST_ACK      = 2'd2;

    localparam logic [5:0] OFS_CTRL      = 6'd0;
    localparam logic [5:0] OFS_STATUS    = 6'd1;
    localparam logic [5:0] OFS_PC        = 6'd2;
    localparam logic [5:0] OFS_WRCOUNT   = 6'd3;
    localparam logic [5:0] OFS_IMEM_ADDR = 6'd4;
    localparam logic [5:0] OFS_IMEM_DATA = 6'd5;

    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    logic [1:0]         state;
    logic [7:0]         tmo_cnt;
    logic               sticky_tmo;
    logic [15:0]        wr_count;
    logic [IMEM_AW-1:0] imem_addr_q;

    logic               selected;
    logic [5:0]         ofs;
    logic [31:0]        rd_data;
    logic [IMEM_AW-1:0] imem_addr_wr;

    logic unused_adr_lsb;
    assign unused_adr_lsb = &{1'b0, wbs.wbs_adr_i[1:0]};

    always_comb begin
        selected = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~wbs.wbs_ack_o &
                   (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        ofs = wbs.wbs_adr_i[7:2];

        rd_data = 32'd0;
        case (ofs)
            OFS_CTRL:      rd_data[1:0] = {core_halt_o, core_rst_o};
            OFS_STATUS:    rd_data[1:0] = {sticky_tmo, imem_wr_valid_o};
            OFS_PC:        rd_data = core_pc_i;
            OFS_WRCOUNT:   rd_data[15:0] = wr_count;
            OFS_IMEM_ADDR: rd_data[IMEM_AW-1:0] = imem_addr_q;
            default:       rd_data = 32'd0;
        endcase

        // Each address bit follows the byte lane it sits in.
        imem_addr_wr = imem_addr_q;
        for (int i = 0; i < IMEM_AW; i++) begin
            if (wbs.wbs_sel_i[i / 8]) imem_addr_wr[i] = wbs.wbs_dat_i[i];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= ST_IDLE;
            wbs.wbs_ack_o   <= 1'b0;
            wbs.wbs_dat_o   <= 32'd0;
            core_rst_o      <= 1'b1;
            core_halt_o     <= 1'b0;
            imem_wr_valid_o <= 1'b0;
            imem_wr_addr_o  <= '0;
            imem_wr_data_o  <= 32'd0;
            imem_wr_mask_o  <= 4'd0;
            imem_addr_q     <= '0;
            wr_count        <= 16'd0;
            sticky_tmo      <= 1'b0;
            tmo_cnt         <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (selected) begin
                        if (wbs.wbs_we_i && ofs == OFS_IMEM_DATA) begin
                            imem_wr_valid_o <= 1'b1;
                            imem_wr_addr_o  <= imem_addr_q;
                            imem_wr_data_o  <= wbs.wbs_dat_i;
                            imem_wr_mask_o  <= wbs.wbs_sel_i;
                            tmo_cnt         <= TMO_LOAD;
                            state           <= ST_WAIT_MEM;
                        end else begin
                            if (wbs.wbs_we_i) begin
                                case (ofs)
                                    OFS_CTRL: begin
                                        if (wbs.wbs_sel_i[0]) begin
                                            core_rst_o  <= wbs.wbs_dat_i[0];
                                            core_halt_o <= wbs.wbs_dat_i[1];
                                        end
                                    end
                                    OFS_STATUS: begin
                                        if (wbs.wbs_sel_i[0] && wbs.wbs_dat_i[1]) sticky_tmo <= 1'b0;
                                    end
                                    OFS_IMEM_ADDR: imem_addr_q <= imem_addr_wr;
                                    default: ;
                                endcase
                            end else begin
                                wbs.wbs_dat_o <= rd_data;
                            end
                            wbs.wbs_ack_o <= 1'b1;
                            state         <= ST_ACK;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    // Ready wins over an expiring timer on the same edge.
                    if (imem_wr_ready_i) begin
                        imem_wr_valid_o <= 1'b0;
                        imem_addr_q     <= imem_addr_q + 1'b1;
                        wr_count        <= wr_count + 16'd1;
                        wbs.wbs_ack_o   <= 1'b1;
                        state           <= ST_ACK;
                    end else if (tmo_cnt == 8'd0) begin
                        imem_wr_valid_o <= 1'b0;
                        sticky_tmo      <= 1'b1;
                        wbs.wbs_ack_o   <= 1'b1;
                        state           <= ST_ACK;
                    end else begin
                        tmo_cnt <= tmo_cnt - 8'd1;
                    end
                end
                ST_ACK: begin
                    wbs.wbs_ack_o <= 1'b0;
                    wbs.wbs_dat_o <= 32'd0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ibnalhaytham_ctrl.sv
// Bench for wb_ibnalhaytham_ctrl: directed register-map scenarios followed by
// random bus traffic compared against a register-level reference model.
module tb_wb_ibnalhaytham_ctrl;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          IMEM_AW = 8;
    localparam int          TIMEOUT = 16;
    localparam int          NEVER   = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_ibnalhaytham_ctrl_if bus ();
    logic [31:0]        core_pc;
    logic               core_rst, core_halt;
    logic               imem_valid, imem_ready;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic [3:0]         imem_mask;

    wb_ibnalhaytham_ctrl #(.BASE_ADDR(BASE), .IMEM_AW(IMEM_AW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs            (bus.slave),
        .core_pc_i      (core_pc),
        .core_rst_o     (core_rst),
        .core_halt_o    (core_halt),
        .imem_wr_valid_o(imem_valid),
        .imem_wr_ready_i(imem_ready),
        .imem_wr_addr_o (imem_addr),
        .imem_wr_data_o (imem_data),
        .imem_wr_mask_o (imem_mask)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // imem responder: ready rises after ready_delay cycles of valid; handshakes are logged.
    int          ready_delay = 0;
    int          vcnt = 0;
    int          last_vlen = 0;
    logic [31:0] hs_addr[$];
    logic [31:0] hs_data[$];
    logic [3:0]  hs_mask[$];

    initial begin
        imem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_valid === 1'b1) begin
                imem_ready = (vcnt >= ready_delay);
                vcnt++;
                if (imem_ready) begin
                    hs_addr.push_back(32'(imem_addr));
                    hs_data.push_back(imem_data);
                    hs_mask.push_back(imem_mask);
                end
            end else begin
                if (vcnt > 0) last_vlen = vcnt;
                imem_ready = 1'b0;
                vcnt = 0;
            end
        end
    end

    // Reference model state
    logic        m_rst, m_halt, m_sticky;
    int unsigned m_addr, m_count;

    task automatic model_reset();
        m_rst = 1'b1; m_halt = 1'b0; m_sticky = 1'b0; m_addr = 0; m_count = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] ofs);
        case (ofs)
            8'h00: return {30'd0, m_halt, m_rst};
            8'h04: return {30'd0, m_sticky, 1'b0};
            8'h08: return core_pc;
            8'h0C: return m_count % 65536;
            8'h10: return m_addr;
            default: return 32'd0;
        endcase
    endfunction

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rd, output int lat);
        logic got;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = wd;   bus.wbs_sel_i = sel;
        lat = 0; rd = 32'd0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.wbs_ack_o === 1'b1) begin
                got = 1'b1;
                rd = bus.wbs_dat_o;
            end
        end
        check("ack_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        check("ack_single", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("dat_idle_zero", bus.wbs_dat_o, 32'd0);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] ofs, input string tag);
        logic [31:0] rd; int lat;
        wb_xfer(BASE | 32'(ofs), 1'b0, 32'd0, 4'hF, rd, lat);
        check({tag, "_data"}, rd, model_read(ofs));
        check({tag, "_lat"}, 32'(lat), 32'd1);
    endtask

    task automatic do_write(input logic [7:0] ofs, input logic [31:0] wd, input logic [3:0] sel,
                            input string tag);
        logic [31:0] rd; int lat;
        wb_xfer(BASE | 32'(ofs), 1'b1, wd, sel, rd, lat);
        case (ofs)
            8'h00: if (sel[0]) begin m_rst = wd[0]; m_halt = wd[1]; end
            8'h04: if (sel[0] && wd[1]) m_sticky = 1'b0;
            8'h10: if (sel[0]) m_addr = wd[7:0];
            default: ;
        endcase
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, m_rst});
        check({tag, "_core_halt"}, {31'd0, core_halt}, {31'd0, m_halt});
    endtask

    task automatic do_imem(input logic [31:0] wd, input logic [3:0] sel, input int delay,
                           input string tag);
        logic [31:0] rd; int lat;
        logic ok;
        ok = (delay < TIMEOUT);
        hs_addr.delete(); hs_data.delete(); hs_mask.delete();
        ready_delay = delay;
        wb_xfer(BASE | 32'h14, 1'b1, wd, sel, rd, lat);
        check({tag, "_hs_count"}, 32'(hs_addr.size()), ok ? 32'd1 : 32'd0);
        if (ok && hs_addr.size() == 1) begin
            check({tag, "_addr"}, hs_addr[0], m_addr);
            check({tag, "_data"}, hs_data[0], wd);
            check({tag, "_mask"}, 32'(hs_mask[0]), 32'(sel));
        end
        check({tag, "_lat"}, 32'(lat), ok ? 32'(2 + delay) : 32'(1 + TIMEOUT));
        if (!ok) check({tag, "_vlen"}, 32'(last_vlen), 32'(TIMEOUT));
        if (ok) begin
            m_addr  = (m_addr + 1) % (1 << IMEM_AW);
            m_count = m_count + 1;
        end else begin
            m_sticky = 1'b1;
        end
        ready_delay = 0;
    endtask

    initial begin
        int no_ack;
        logic [7:0] ofs_list [8];
        ofs_list = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'hFC};

        rst = 1'b1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = 32'd0; bus.wbs_adr_i = 32'd0;
        core_pc = 32'h0000_0120;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("rst_valid", {31'd0, imem_valid}, 32'd0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_core_halt", {31'd0, core_halt}, 32'd0);

        do_read(8'h00, "ctrl_reset");
        do_write(8'h00, 32'h2, 4'b0001, "ctrl_wr");
        do_read(8'h00, "ctrl_rb");

        do_write(8'h10, 32'hFE, 4'hF, "iaddr_wr");
        do_imem(32'hDEADBEEF, 4'hF, 2, "imem0");
        do_imem(32'h12345678, 4'hF, 2, "imem1");
        do_read(8'h10, "iaddr_wrap");
        do_read(8'h0C, "wrcount2");

        do_imem(32'hCAFEF00D, 4'hF, NEVER, "imem_tmo");
        do_read(8'h04, "status_tmo");
        do_read(8'h10, "iaddr_after_tmo");
        do_read(8'h0C, "wrcount_after_tmo");
        do_write(8'h04, 32'h2, 4'b0001, "status_clr");
        do_read(8'h04, "status_cleared");

        do_imem(32'hA5A5A5A5, 4'b0110, TIMEOUT - 1, "imem_edge_ok");
        do_imem(32'h5A5A5A5A, 4'b1001, TIMEOUT, "imem_edge_tmo");
        do_write(8'h04, 32'h2, 4'b0001, "status_clr2");

        // Foreign address: never acked.
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = 32'h3100_0000;
        no_ack = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o === 1'b1) no_ack++;
        end
        check("foreign_no_ack", 32'(no_ack), 32'd0);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;

        do_read(8'h40, "unmapped");
        do_read(8'h08, "pc");

        for (int n = 0; n < 80; n++) begin
            int op;
            logic [7:0] ofs;
            op = $urandom_range(0, 9);
            core_pc = $urandom;
            ofs = ofs_list[$urandom_range(0, 7)];
            if (op < 3) begin
                if (ofs == 8'h14) ofs = 8'h14;
                do_read(ofs, "rnd_rd");
            end else if (op < 6) begin
                do_imem($urandom, 4'($urandom), ($urandom_range(0, 15) == 0) ? TIMEOUT : $urandom_range(0, 4),
                        "rnd_imem");
            end else begin
                if (ofs == 8'h14) ofs = 8'h10;
                do_write(ofs, $urandom, 4'($urandom), "rnd_wr");
            end
        end
        do_read(8'h0C, "rnd_wrcount");
        do_read(8'h10, "rnd_iaddr");

        // Reset in the middle of an outstanding imem write.
        do_write(8'h00, 32'h2, 4'b0001, "pre_rst_ctrl");
        ready_delay = NEVER;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = BASE | 32'h14; bus.wbs_dat_i = 32'h1111_2222; bus.wbs_sel_i = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        check("midwait_valid", {31'd0, imem_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", {31'd0, imem_valid}, 32'd0);
        check("midrst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("midrst_core_rst", {31'd0, core_rst}, 32'd1);
        check("midrst_mask", 32'(imem_mask), 32'd0);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        rst = 1'b0;
        ready_delay = 0;
        model_reset();
        do_read(8'h00, "post_rst_ctrl");
        do_read(8'h10, "post_rst_iaddr");
        do_read(8'h0C, "post_rst_wrcount");
        do_read(8'h04, "post_rst_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end
endmodule
